// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared FSM state, access-size encodings and default LED address
package data_memory_pkg;
  typedef enum logic [1:0] {IDLE, LATCH, READ, WRITE} state_t;
  localparam logic [2:0] SIZE_BYTE = 3'b001;
  localparam logic [2:0] SIZE_HALF = 3'b011;
  localparam logic [2:0] SIZE_WORD = 3'b111;
  localparam int SIGNED_BIT = 3;
  localparam logic [31:0] DEFAULT_LED_ADDR = 32'h0000_2000;
endpackage

// File: rtl/data_memory_ram.sv
// data_ram: single-port 32-bit RAM, registered read, word write (ports: clk, addr, we, wdata, rdata)
module data_ram #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_memory.sv
// data_memory: RV32I byte-addressable load/store unit with LED register (ports: clk, rst, addr, write_data, memwrite, memread, sign_mask, read_data, led, clk_stall)
module data_memory
  import data_memory_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] LED_ADDR    = DEFAULT_LED_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic [7:0]  led,
  output logic        clk_stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_n;
  logic [31:0] addr_q, wdata_q, merged_q, ram_rdata;
  logic [3:0] mask_q;
  logic wr_q, is_led, ram_we;
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a, input logic [3:0] m);
    logic [7:0] b;
    logic [15:0] h;
    logic s;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    s = m[SIGNED_BIT];
    return m[2:0] == SIZE_BYTE ? {{24{s & b[7]}}, b} :
           m[2:0] == SIZE_HALF ? {{16{s & h[15]}}, h} : w;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [1:0] a, input logic [2:0] sz);
    logic [31:0] m;
    logic [4:0] sh;
    m  = sz == SIZE_BYTE ? 32'h0000_00ff : sz == SIZE_HALF ? 32'h0000_ffff : 32'hffff_ffff;
    sh = sz == SIZE_BYTE ? {a, 3'b000} : sz == SIZE_HALF ? {a[1], 4'b0000} : 5'd0;
    return (w & ~(m << sh)) | ((d & m) << sh);
  endfunction
  assign is_led    = addr_q[31:2] == LED_ADDR[31:2];
  assign clk_stall = state != IDLE;
  assign ram_we    = state == WRITE && !is_led && !rst;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? ((memwrite || memread) ? LATCH : IDLE) :
              state == LATCH ? READ :
              state == READ  ? (wr_q ? WRITE : IDLE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      read_data <= '0;
      led       <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (memwrite || memread)) begin
        addr_q  <= addr;
        wdata_q <= write_data;
        mask_q  <= sign_mask;
        wr_q    <= memwrite;
      end
      if (state == READ && wr_q) merged_q <= merge(ram_rdata, wdata_q, addr_q[1:0], mask_q[2:0]);
      if (state == READ && !wr_q) read_data <= extract(is_led ? {24'b0, led} : ram_rdata, addr_q[1:0], mask_q);
      if (state == WRITE && is_led) led <= wdata_q[7:0];
    end
  end
  data_ram #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk  (clk),
    .addr (addr_q[AW+1:2]),
    .we   (ram_we),
    .wdata(merged_q),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized scoreboard bench for data_memory against a byte-array model
module tb_data_memory;
  logic clk = 0, rst = 1, memwrite = 0, memread = 0;
  logic [31:0] addr = 0, write_data = 0;
  logic [3:0] sign_mask = 0;
  logic [31:0] read_data;
  logic [7:0] led;
  logic clk_stall;
  int errors = 0, checks = 0;
  typedef struct {bit ld; logic [31:0] rd; logic [7:0] led; int stall;} exp_t;
  exp_t q[$];
  logic [7:0] mem_b [int];
  logic [7:0] led_m = 0;
  logic [31:0] rd_m = 0;
  bit abort_pending = 0;
  always #5 clk = ~clk;
  data_memory dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
    .read_data(read_data), .led(led), .clk_stall(clk_stall)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] get_b(input int i);
    return mem_b.exists(i) ? mem_b[i] : 8'h00;
  endfunction
  task automatic op(input bit w, input bit both, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int sz, off, wi, n;
    logic [31:0] v;
    bit led_hit;
    exp_t e;
    sz = m[2:0] == 3'b001 ? 1 : m[2:0] == 3'b011 ? 2 : 4;
    off = sz == 1 ? int'(a[1:0]) : sz == 2 ? (a[1] ? 2 : 0) : 0;
    wi = int'((a >> 2) & 32'h3ff);
    led_hit = (a >> 2) == (32'h2000 >> 2);
    if (w) begin
      if (led_hit) led_m = d[7:0];
      else for (int i = 0; i < sz; i++) mem_b[wi*4+off+i] = d[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = led_hit ? ((off + i) == 0 ? led_m : 8'h00) : get_b(wi*4+off+i);
      if (m[3] && v[8*sz-1]) for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
      rd_m = v;
    end
    e.ld = !w; e.rd = rd_m; e.led = led_m; e.stall = w ? 3 : 2;
    q.push_back(e);
    memwrite = w; memread = !w || both; addr = a; write_data = d; sign_mask = m;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (clk_stall && n < 8) begin
      memwrite = 1'($urandom_range(0, 1)); memread = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 63); write_data = $urandom; sign_mask = 4'($urandom);
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("stall_timeout", 32'(n), 32'd0);
    memwrite = 0; memread = 0;
  endtask
  int run = 0;
  bit prev_stall = 0;
  always @(negedge clk) begin
    exp_t e;
    if (clk_stall) run++;
    else if (prev_stall) begin
      if (abort_pending) abort_pending = 0;
      else if (q.size() == 0) chk("unexpected_completion", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk(e.ld ? "load_read_data" : "store_read_data_hold", read_data, e.rd);
        chk("led", {24'b0, led}, {24'b0, e.led});
        chk("stall_cycles", 32'(run), 32'(e.stall));
      end
      run = 0;
    end
    prev_stall = clk_stall;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] a;
    bit w;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_stall", {31'b0, clk_stall}, 32'd0);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_led", {24'b0, led}, 32'd0);
    for (int i = 0; i < 16; i++) op(1, 0, 32'(i * 4), $urandom, 4'b0111);
    op(1, 0, 32'h10, 32'hcafe_f00d, 4'b0111);
    op(1, 0, 32'h400, 32'haaa, 4'b0001);
    op(0, 0, 32'h400, 0, 4'b1001);
    chk("spec_sbyte", read_data, 32'hffff_ffaa);
    op(0, 0, 32'h400, 0, 4'b0001);
    chk("spec_ubyte", read_data, 32'h0000_00aa);
    op(1, 0, 32'h100, 32'h2aaaa, 4'b0011);
    op(0, 0, 32'h100, 0, 4'b1011);
    chk("spec_shalf", read_data, 32'hffff_aaaa);
    op(0, 0, 32'h100, 0, 4'b0011);
    chk("spec_uhalf", read_data, 32'h0000_aaaa);
    op(1, 0, 32'h40, 32'haaaa_aaaa, 4'b0111);
    op(0, 0, 32'h40, 0, 4'b0111);
    chk("spec_word", read_data, 32'haaaa_aaaa);
    op(1, 0, 32'h80, 32'h1122_3344, 4'b0111);
    op(1, 0, 32'h82, 32'hee, 4'b0001);
    op(0, 0, 32'h80, 0, 4'b0111);
    chk("spec_lanes", read_data, 32'h11ee_3344);
    op(0, 0, 32'h82, 0, 4'b0011);
    chk("spec_lane_half", read_data, 32'h0000_11ee);
    op(1, 0, 32'h2000, 32'h5a, 4'b0111);
    chk("spec_led", {24'b0, led}, 32'h5a);
    op(0, 0, 32'h0, 0, 4'b0111);
    op(0, 0, 32'h2000, 0, 4'b0001);
    chk("spec_led_load", read_data, 32'h0000_005a);
    memwrite = 1; addr = 32'h10; write_data = 0; sign_mask = 4'b0111;
    @(posedge clk);
    @(negedge clk);
    memwrite = 0;
    @(negedge clk);
    chk("abort_in_progress", {31'b0, clk_stall}, 32'd1);
    abort_pending = 1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("abort_stall", {31'b0, clk_stall}, 32'd0);
    chk("abort_led", {24'b0, led}, 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    led_m = 0; rd_m = 0;
    op(0, 0, 32'h10, 0, 4'b0111);
    chk("abort_discarded", read_data, 32'hcafe_f00d);
    for (int k = 0; k < 300; k++) begin
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 9) == 0 ? 32'h2000 + $urandom_range(0, 3) : 32'($urandom_range(0, 63)) | ($urandom_range(0, 1) << 12);
      op(w, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    end
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
